bcd_conv_sched: RTL
===================

# bcd_conv_sched

Round-robin scheduler that shares one iterative binary-to-BCD conversion engine among several requesters. Requesters are RTC field formatters (seconds, minutes, hours, date) feeding the VGA text overlay and the RTC write path. Each request is an 8-bit binary value; the block returns hundreds, tens and ones digits after a fixed multi-cycle double-dabble sequence. One conversion is in flight at a time, and results are tagged back to the issuing requester by a one-hot pulse.

## Interface
Parameters:
- NREQ, default 4: number of requesters (2..8).

Ports:
- clk, in, 1: single clock; all state updates on its rising edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- req_valid, in, NREQ: request from requester i.
- req_bin, in, 8*NREQ: packed operands; requester i occupies bits [8i+7:8i].
- req_ready, out, NREQ: one-hot accept. Combinational, asserted only in IDLE.
- rsp_valid, out, NREQ: one-hot, one-cycle result pulse to the original requester.
- rsp_bcd, out, 8: {tens, ones}. Registered; holds until the next result.
- rsp_hund, out, 4: hundreds digit (0..2). Registered; holds until the next result.
- busy, out, 1: high in SHIFT and DONE.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - If any req_valid is high, the arbiter picks the first requester at or after rr_ptr, wrapping modulo NREQ.
  - req_ready[winner] is 1 in that cycle. All other req_ready bits are 0.
  - On the clock edge, the block latches req_bin[winner] and the winner index, clears the shift register (20 bits: hund/tens/ones/operand), sets cnt=0, sets rr_ptr=(winner+1) mod NREQ, and moves to SHIFT.
- SHIFT, one iteration per cycle:
  - Each BCD nibble that is ≥5 gets +3.
  - Then the whole 20-bit register shifts left by 1.
  - cnt increments. When cnt==7 on this edge, the FSM moves to DONE. Exactly 8 iterations are performed.
- DONE:
  - rsp_valid[id]=1 for exactly this cycle.
  - rsp_bcd and rsp_hund were loaded on the edge entering DONE.
  - Next state is IDLE. No grant is issued in DONE.
- Arithmetic: the input range is 0..255. rsp_hund is at most 2. Nibble corrections are 4-bit and cannot overflow, because the value is ≥5 only before a shift.
- Requester contract:
  - Hold req_valid and req_bin stable until req_ready.
  - Drop req_valid the cycle after acceptance, or keep it high to queue another request.
  - req_bin changes after acceptance are ignored.
- Requests from idle requesters never block others. A requester holding req_valid is served within NREQ grants.

## Timing
- Acceptance happens in cycle T (IDLE with req_ready high). SHIFT occupies T+1..T+8. rsp_valid is high in T+9. IDLE resumes at T+10.
- Latency is 9 cycles. Throughput is one conversion per 10 cycles.
- Reset values: FSM=IDLE, rr_ptr=0, rsp_valid=0, rsp_bcd=8'h00, rsp_hund=4'h0, busy=0, and req_ready follows IDLE with no requests (0).
- Reset asserted mid-conversion: the block returns to IDLE immediately and asynchronously, and the in-flight result is discarded with no rsp_valid. The accepted requester must re-request.
- Simultaneous requests in IDLE: exactly one grant, chosen by the round-robin order above.
- A new req_valid arriving during SHIFT or DONE waits; req_ready stays 0.

## Structure
- Shared package bcd_pkg holds:
  - BIN_W=8
  - BCD_W=4
  - N_ITER=8
  - the state encoding localparams (ST_IDLE, ST_SHIFT, ST_DONE)
- Sub-module bcd_dd_iter: an iterative double-dabble core with start, operand[7:0], done, hund, tens and ones. It owns the 20-bit shift register and cnt.
- bcd_conv_sched keeps the arbiter, rr_ptr, the id register and the response registers.

## Test plan
- Reset, then req_valid[0] with 8'd59: req_ready[0]=1 in that cycle; 9 cycles later rsp_valid=4'b0001, rsp_bcd=8'h59, rsp_hund=0.
- Boundary values: 8'd255 gives rsp_hund=2, rsp_bcd=8'h55. 8'd0 gives 0 and 8'h00. 8'd100 gives 1 and 8'h00.
- After reset, all four requesters assert at once with 12, 34, 56, 78: they are served in order 0,1,2,3, with rsp_valid pulses 10 cycles apart carrying 8'h12, 8'h34, 8'h56, 8'h78.
- Requesters 1 and 3 hold req_valid continuously: grants alternate 1,3,1,3, and requester 0 and requester 2 never receive req_ready.
- rst_n pulled low during the 4th SHIFT cycle: all outputs go to reset values without waiting for clk, and no rsp_valid is ever emitted. After release, requesters 2 and 3 both requesting yields a first grant to 2 (pointer is 0).
- Sweep of all values 0..255 through requester NREQ-1: every result matches the reference model, and busy is high in exactly 9 of every 10 cycles.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared widths, iteration count and FSM encoding for the BCD
//            conversion scheduler.
// Revision : 1.0
// ============================================================================
package bcd_pkg;

  localparam int BIN_W  = 8;
  localparam int BCD_W  = 4;
  localparam int N_ITER = 8;
  localparam int SR_W   = BIN_W + 3 * BCD_W;
  localparam int CNT_W  = $clog2(N_ITER);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Add-3 correction applied to a BCD digit ahead of each shift.
  function automatic logic [BCD_W-1:0] dd_adj(input logic [BCD_W-1:0] d);
    return (d >= BCD_W'(5)) ? d + BCD_W'(3) : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dd_iter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_dd_iter
// Brief    : Iterative double-dabble core, one add-3/shift step per cycle.
// Revision : 1.0
// ============================================================================
module bcd_dd_iter
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] operand,
  output logic             done,
  output logic [BCD_W-1:0] hund,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  logic [SR_W-1:0]  r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic [SR_W-1:0]  w_adj;
  logic [SR_W-1:0]  w_next;

  always_comb begin
    w_adj  = {dd_adj(r_sr[SR_W-1 -: BCD_W]),
              dd_adj(r_sr[SR_W-1-BCD_W -: BCD_W]),
              dd_adj(r_sr[SR_W-1-2*BCD_W -: BCD_W]),
              r_sr[BIN_W-1:0]};
    w_next = w_adj << 1;
  end

  // Digits are presented from the post-step value so the final step's result
  // can be captured on the same edge that completes it.
  assign hund = w_next[SR_W-1 -: BCD_W];
  assign tens = w_next[SR_W-1-BCD_W -: BCD_W];
  assign ones = w_next[SR_W-1-2*BCD_W -: BCD_W];
  assign done = r_active && (r_cnt == CNT_W'(N_ITER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr     <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_sr     <= {{(3*BCD_W){1'b0}}, operand};
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_sr  <= w_next;
      r_cnt <= r_cnt + 1'b1;
      if (done) r_active <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_conv_sched.sv
`default_nettype none
// ============================================================================
// Module   : bcd_conv_sched
// Brief    : Round-robin scheduler sharing one double-dabble engine among NREQ
//            requesters, returning tagged BCD results.
// Revision : 1.0
// ============================================================================
module bcd_conv_sched
  import bcd_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [BIN_W*NREQ-1:0] req_bin,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [2*BCD_W-1:0]    rsp_bcd,
  output logic [BCD_W-1:0]      rsp_hund,
  output logic                  busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              r_state;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    r_id;
  logic [NREQ-1:0]     r_rsp_valid;
  logic [2*BCD_W-1:0]  r_rsp_bcd;
  logic [BCD_W-1:0]    r_rsp_hund;

  logic                w_win_found;
  logic [PTR_W-1:0]    w_win_idx;
  logic [PTR_W-1:0]    w_cand_idx;
  int                  w_cand;
  logic [NREQ-1:0]     w_grant;
  logic                w_start;
  logic [BIN_W-1:0]    w_operand;
  logic [PTR_W-1:0]    w_ptr_next;
  logic                w_done;
  logic [BCD_W-1:0]    w_hund;
  logic [BCD_W-1:0]    w_tens;
  logic [BCD_W-1:0]    w_ones;

  // Scan from rr_ptr upward, wrapping, and keep the first active requester.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = 0;
    w_cand_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = int'(r_rr_ptr) + k;
      if (w_cand >= NREQ) w_cand = w_cand - NREQ;
      w_cand_idx = PTR_W'(w_cand);
      if (!w_win_found && req_valid[w_cand_idx]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand_idx;
      end
    end
  end

  assign w_start = (r_state == ST_IDLE) && w_win_found;

  always_comb begin
    w_grant = '0;
    if (w_start) w_grant[w_win_idx] = 1'b1;
  end

  assign w_operand  = req_bin[int'(w_win_idx)*BIN_W +: BIN_W];
  assign w_ptr_next = (w_win_idx == PTR_W'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;

  bcd_dd_iter u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_start),
    .operand (w_operand),
    .done    (w_done),
    .hund    (w_hund),
    .tens    (w_tens),
    .ones    (w_ones)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_rsp_valid <= '0;
      r_rsp_bcd   <= '0;
      r_rsp_hund  <= '0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_found) begin
            r_id     <= w_win_idx;
            r_rr_ptr <= w_ptr_next;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_done) begin
            r_rsp_bcd         <= {w_tens, w_ones};
            r_rsp_hund        <= w_hund;
            r_rsp_valid[r_id] <= 1'b1;
            r_state           <= ST_DONE;
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_bcd   = r_rsp_bcd;
  assign rsp_hund  = r_rsp_hund;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
